// File: rtl/cotm32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cotm32_pkg
// Description : Shared types and defaults for the cotm32 memory subsystem.
//               Holds the data-memory arbiter state encoding and its default
//               requester count / lock hold limit.
// Revision    : 1.0 - initial release
// ============================================================================
package cotm32_pkg;

    // Arbiter state: IDLE does a round-robin scan, LOCKED favours the owner.
    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int DMEM_ARB_NREQ     = 2;
    localparam int DMEM_ARB_MAX_HOLD = 4;

endpackage : cotm32_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin first-set finder. Scans the request
//               vector starting at i_ptr and wrapping modulo N, and returns
//               the first set position as a one-hot grant and an index.
// Ports       : i_req   [N]          request vector
//               i_ptr   [clog2(N)]   scan start position
//               o_grant [N]          one-hot grant (all zero if no request)
//               o_idx   [clog2(N)]   index of the granted position
//               o_valid              any request found
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_valid
);

    localparam int IDW = $clog2(N);

    always_comb begin
        int  k;
        logic found;
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(i_ptr) + i) % N;
            if (!found && i_req[k]) begin
                found      = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = IDW'(k);
            end
        end
        o_valid = found;
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares a single-port data memory between N_REQ requesters
//               (port 0 = core LSU, others = DMA/debug loader). Combinational
//               round-robin grant with an optional bounded lock, 1-cycle
//               registered read response, core stall and flush suppression.
// Ports       : i_clk, i_rst          clock, synchronous active-high reset
//               i_flush               kills the port-0 request this cycle
//               i_req_*               per-port request (flattened buses)
//               o_req_ready           one-hot grant this cycle
//               o_rsp_valid/id/rdata  registered read response
//               o_core_stall          port 0 waiting for the memory
//               o_mem_*, i_mem_rdata  single-port memory interface
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import cotm32_pkg::*;
#(
    parameter int N_REQ      = DMEM_ARB_NREQ,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = DMEM_ARB_MAX_HOLD
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_flush,
    input  logic [N_REQ-1:0]               i_req_valid,
    input  logic [N_REQ-1:0]               i_req_lock,
    input  logic [N_REQ-1:0]               i_req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0]    i_req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]    i_req_wdata,
    input  logic [N_REQ*DATA_WIDTH/8-1:0]  i_req_wstrb,
    output logic [N_REQ-1:0]               o_req_ready,
    output logic                           o_rsp_valid,
    output logic [$clog2(N_REQ)-1:0]       o_rsp_id,
    output logic [DATA_WIDTH-1:0]          o_rsp_rdata,
    output logic                           o_core_stall,
    output logic                           o_mem_we,
    output logic [ADDR_WIDTH-1:0]          o_mem_addr,
    output logic [DATA_WIDTH-1:0]          o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0]        o_mem_wstrb,
    input  logic [DATA_WIDTH-1:0]          i_mem_rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDW    = $clog2(N_REQ);
    // hold_cnt never exceeds MAX_HOLD-1; one spare bit keeps MAX_HOLD=1 legal.
    localparam int HW     = $clog2(MAX_HOLD) + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t              state_q,     state_d;
    logic [IDW-1:0]          rr_ptr_q,    rr_ptr_d;
    logic [IDW-1:0]          owner_q,     owner_d;
    logic [HW-1:0]           hold_cnt_q,  hold_cnt_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]          rsp_id_q,    rsp_id_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] w_ev;
    logic [N_REQ-1:0] w_rr_grant;
    logic [IDW-1:0]   w_rr_idx;
    logic             w_rr_valid;
    logic             w_owner_hit;
    logic             w_gnt_valid;
    logic [IDW-1:0]   w_gnt_idx;
    logic [N_REQ-1:0] w_grant;
    logic [HW-1:0]    w_hold_base;

    // A flushed core request is invisible to arbitration.
    always_comb begin
        w_ev    = i_req_valid;
        w_ev[0] = i_req_valid[0] & ~i_flush;
    end

    rr_pick #(
        .N (N_REQ)
    ) u_rr_pick (
        .i_req   (w_ev),
        .i_ptr   (rr_ptr_q),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_valid (w_rr_valid)
    );

    // A locked owner that still requests wins outright; otherwise the
    // round-robin result applies (also the fallback when the owner drops).
    always_comb begin
        w_owner_hit = (state_q == ARB_LOCKED) && w_ev[owner_q];
        w_gnt_valid = w_owner_hit | w_rr_valid;
        w_gnt_idx   = w_rr_idx;
        w_grant     = w_rr_grant;
        if (w_owner_hit) begin
            w_gnt_idx          = owner_q;
            w_grant            = '0;
            w_grant[owner_q]   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            hold_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            hold_cnt_q  <= hold_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        hold_cnt_d  = hold_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_rdata_d = rsp_rdata_q;
        // Consecutive-grant count only carries over while the grantee is the
        // same port; a new grantee starts from zero.
        w_hold_base = (w_gnt_idx == owner_q) ? hold_cnt_q : '0;

        if (w_gnt_valid) begin
            rr_ptr_d = (int'(w_gnt_idx) == N_REQ - 1) ? '0 : w_gnt_idx + IDW'(1);
            if (i_req_lock[w_gnt_idx] && (int'(w_hold_base) + 1 < MAX_HOLD)) begin
                state_d    = ARB_LOCKED;
                owner_d    = w_gnt_idx;
                hold_cnt_d = w_hold_base + HW'(1);
            end else begin
                state_d    = ARB_IDLE;
                hold_cnt_d = '0;
            end
            if (!i_req_we[w_gnt_idx]) begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = w_gnt_idx;
                rsp_rdata_d = i_mem_rdata;
            end
        end else if (state_q == ARB_LOCKED) begin
            // Owner vanished (or was flushed) and nobody else asks.
            state_d    = ARB_IDLE;
            hold_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_req_ready  = w_grant;
        o_core_stall = w_ev[0] & ~w_grant[0];
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_wstrb  = '0;
        if (w_gnt_valid) begin
            o_mem_we    = i_req_we[w_gnt_idx];
            o_mem_addr  = i_req_addr [int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            o_mem_wdata = i_req_wdata[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            o_mem_wstrb = i_req_wstrb[int'(w_gnt_idx)*STRB_W     +: STRB_W];
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_rdata = rsp_rdata_q;

endmodule : dmem_arbiter
`default_nettype wire
